// File: rtl/test_bsg_loopback_pkg.sv
// Shared defaults and flit/header layouts for the loopback traffic channel.
// A flit is packed LSB first as cord, then len, then zero-extended data.
package test_bsg_loopback_pkg;

  localparam int lb_flit_width_lp    = 32;
  localparam int lb_cord_width_lp    = 5;
  localparam int lb_len_width_lp     = 2;
  localparam int lb_num_channels_lp  = 2;
  localparam int lb_channel_width_lp = 8;
  localparam int lb_data_width_lp    = lb_num_channels_lp * lb_channel_width_lp;
  localparam int lb_field_width_lp   = lb_flit_width_lp - lb_cord_width_lp - lb_len_width_lp;

  typedef struct packed {
    logic [lb_len_width_lp-1:0]  len;
    logic [lb_cord_width_lp-1:0] cord;
  } lb_hdr_s;

  typedef struct packed {
    logic [lb_field_width_lp-1:0] data;
    lb_hdr_s                      hdr;
  } lb_flit_s;

  function automatic lb_flit_s lb_make_flit(input logic [lb_data_width_lp-1:0] data,
                                            input logic [lb_cord_width_lp-1:0] cord);
    lb_flit_s f;
    f.data     = lb_field_width_lp'(data);
    f.hdr.len  = {lb_len_width_lp{1'b0}};
    f.hdr.cord = cord;
    return f;
  endfunction

endpackage

// File: rtl/bsg_counter_clear_up.sv
// Wrapping up-counter with synchronous clear; width sized to hold max_val_p.
module bsg_counter_clear_up #(
  parameter logic [63:0] max_val_p = 64'hFFFF_FFFF,
  localparam int         width_lp  = $clog2(max_val_p + 64'd1)
) (
  input  logic                clk_i,
  input  logic                reset_n_i,
  input  logic                clear_i,
  input  logic                up_i,
  output logic [width_lp-1:0] count_o
);

  logic [width_lp-1:0] r_count;
  logic [width_lp-1:0] w_count_next;

  // clear takes precedence over the held value, then the increment is added
  always_comb begin
    w_count_next = r_count;
    if (clear_i) begin
      w_count_next = width_lp'(up_i);
    end else begin
      w_count_next = r_count + width_lp'(up_i);
    end
  end

  // count register
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_count <= {width_lp{1'b0}};
    end else begin
      r_count <= w_count_next;
    end
  end

  assign count_o = r_count;

endmodule

// File: rtl/bsg_one_fifo.sv
// Single-entry valid/ready buffer: accepts only when empty, so enqueue and
// dequeue are never simultaneous.
module bsg_one_fifo
  import test_bsg_loopback_pkg::*;
#(
  parameter int width_p = lb_flit_width_lp
) (
  input  logic               clk_i,
  input  logic               reset_n_i,
  input  logic               v_i,
  input  logic [width_p-1:0] data_i,
  output logic               ready_and_o,
  output logic               v_o,
  output logic [width_p-1:0] data_o,
  input  logic               yumi_i
);

  logic               r_full;
  logic [width_p-1:0] r_data;
  logic               w_enq;

  assign w_enq       = v_i & ~r_full;
  assign ready_and_o = ~r_full;
  assign v_o         = r_full;
  assign data_o      = r_data;

  // occupancy flag and storage word
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_full <= 1'b0;
      r_data <= {width_p{1'b0}};
    end else if (w_enq) begin
      r_full <= 1'b1;
      r_data <= data_i;
    end else if (yumi_i) begin
      r_full <= 1'b0;
    end else begin
      r_full <= r_full;
    end
  end

endmodule

// File: rtl/test_bsg_data_gen.sv
// Deterministic pattern source: channel k carries counter+k; the counter
// steps (and wraps) each cycle the consumer takes the current word.
module test_bsg_data_gen
  import test_bsg_loopback_pkg::*;
#(
  parameter int channel_width_p = lb_channel_width_lp,
  parameter int num_channels_p  = lb_num_channels_lp
) (
  input  logic                                      clk_i,
  input  logic                                      reset_n_i,
  input  logic                                      yumi_i,
  output logic [num_channels_p*channel_width_p-1:0] data_o
);

  logic [channel_width_p-1:0] r_cnt;

  // pattern counter
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_cnt <= {channel_width_p{1'b0}};
    end else if (yumi_i) begin
      r_cnt <= r_cnt + {{(channel_width_p-1){1'b0}}, 1'b1};
    end else begin
      r_cnt <= r_cnt;
    end
  end

  for (genvar k = 0; k < num_channels_p; k++) begin : g_chan
    assign data_o[k*channel_width_p +: channel_width_p] = r_cnt + channel_width_p'(k);
  end

endmodule

// File: rtl/test_bsg_loopback_channel.sv
// Traffic channel: generates single-flit packets toward dest_cord_i and
// checks looped-back flits against an identical pattern source.
module test_bsg_loopback_channel
  import test_bsg_loopback_pkg::*;
#(
  parameter int flit_width_p    = lb_flit_width_lp,
  parameter int cord_width_p    = lb_cord_width_lp,
  parameter int len_width_p     = lb_len_width_lp,
  parameter int num_channels_p  = lb_num_channels_lp,
  parameter int channel_width_p = lb_channel_width_lp
) (
  input  logic                    clk_i,
  input  logic                    reset_n_i,
  input  logic                    en_i,
  input  logic [cord_width_p-1:0] dest_cord_i,
  input  logic                    link_v_i,
  input  logic [flit_width_p-1:0] link_data_i,
  output logic                    link_ready_and_o,
  output logic                    link_v_o,
  output logic [flit_width_p-1:0] link_data_o,
  input  logic                    link_ready_and_i,
  output logic                    error_o,
  output logic [31:0]             sent_o,
  output logic [31:0]             received_o
);

  localparam int data_width_lp = num_channels_p * channel_width_p;
  localparam int data_lsb_lp   = cord_width_p + len_width_p;

  if (data_width_lp > flit_width_p - cord_width_p - len_width_p) begin : g_width_check
    $error("pattern data does not fit in the flit payload");
  end

  logic                     w_tx_ready;
  logic                     w_send;
  logic [data_width_lp-1:0] w_gen_tx;
  logic [flit_width_p-1:0]  w_tx_flit;
  logic                     w_rx_v;
  logic [flit_width_p-1:0]  w_rx_data;
  logic [data_width_lp-1:0] w_gen_rx;
  logic                     w_mismatch;
  logic                     r_error;
  logic                     w_unused;

  assign w_send    = en_i & w_tx_ready;
  assign w_tx_flit = flit_width_p'({w_gen_tx, {len_width_p{1'b0}}, dest_cord_i});

  test_bsg_data_gen #(.channel_width_p(channel_width_p), .num_channels_p(num_channels_p)) u_gen_tx (
    .clk_i(clk_i), .reset_n_i(reset_n_i), .yumi_i(w_send), .data_o(w_gen_tx)
  );

  bsg_one_fifo #(.width_p(flit_width_p)) u_tx_fifo (
    .clk_i(clk_i), .reset_n_i(reset_n_i),
    .v_i(en_i), .data_i(w_tx_flit), .ready_and_o(w_tx_ready),
    .v_o(link_v_o), .data_o(link_data_o), .yumi_i(link_v_o & link_ready_and_i)
  );

  // receive side drains its buffer the same cycle a flit is held
  bsg_one_fifo #(.width_p(flit_width_p)) u_rx_fifo (
    .clk_i(clk_i), .reset_n_i(reset_n_i),
    .v_i(link_v_i), .data_i(link_data_i), .ready_and_o(link_ready_and_o),
    .v_o(w_rx_v), .data_o(w_rx_data), .yumi_i(w_rx_v)
  );

  test_bsg_data_gen #(.channel_width_p(channel_width_p), .num_channels_p(num_channels_p)) u_gen_rx (
    .clk_i(clk_i), .reset_n_i(reset_n_i), .yumi_i(w_rx_v), .data_o(w_gen_rx)
  );

  assign w_mismatch = w_rx_data[data_lsb_lp +: data_width_lp] != w_gen_rx;
  assign w_unused   = ^{w_rx_data};

  // sticky mismatch flag, cleared only by reset
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_error <= 1'b0;
    end else if (w_rx_v && w_mismatch) begin
      r_error <= 1'b1;
      $info("loopback data mismatch: got %0h want %0h",
            w_rx_data[data_lsb_lp +: data_width_lp], w_gen_rx);
    end else begin
      r_error <= r_error;
    end
  end

  assign error_o = r_error;

  bsg_counter_clear_up #(.max_val_p(64'hFFFF_FFFF)) u_sent_cnt (
    .clk_i(clk_i), .reset_n_i(reset_n_i), .clear_i(1'b0), .up_i(w_send), .count_o(sent_o)
  );

  bsg_counter_clear_up #(.max_val_p(64'hFFFF_FFFF)) u_recv_cnt (
    .clk_i(clk_i), .reset_n_i(reset_n_i), .clear_i(1'b0), .up_i(w_rx_v), .count_o(received_o)
  );

endmodule

// File: tb/tb_test_bsg_loopback_channel.sv
// Directed bench for test_bsg_loopback_channel: reset, transmit pattern,
// back-pressure, full loopback with pattern wrap, error injection, async reset.
module tb_test_bsg_loopback_channel;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic [4:0]  dest = 5'h00;
  logic        loop = 1'b0;
  logic        drv_v = 1'b0;
  logic [31:0] drv_data = 32'h0;
  logic        drv_ready = 1'b0;

  logic        link_ready_and_o;
  logic        link_v_o;
  logic [31:0] link_data_o;
  logic        error_o;
  logic [31:0] sent_o;
  logic [31:0] received_o;
  logic        link_v_i;
  logic [31:0] link_data_i;
  logic        link_ready_and_i;

  int checks = 0;
  int errors = 0;

  assign link_v_i         = loop ? link_v_o : drv_v;
  assign link_data_i      = loop ? link_data_o : drv_data;
  assign link_ready_and_i = loop ? link_ready_and_o : drv_ready;

  always #5 clk = ~clk;

  test_bsg_loopback_channel dut (
    .clk_i(clk), .reset_n_i(rst_n), .en_i(en), .dest_cord_i(dest),
    .link_v_i(link_v_i), .link_data_i(link_data_i), .link_ready_and_o(link_ready_and_o),
    .link_v_o(link_v_o), .link_data_o(link_data_o), .link_ready_and_i(link_ready_and_i),
    .error_o(error_o), .sent_o(sent_o), .received_o(received_o)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step(1);
    rst_n = 1'b1;
  endtask

  initial begin
    // reset held: outputs at reset values
    #3;
    check("rst_v", {31'd0, link_v_o}, 32'd0);
    check("rst_err", {31'd0, error_o}, 32'd0);
    check("rst_sent", sent_o, 32'd0);
    check("rst_recv", received_o, 32'd0);
    step(2);
    rst_n = 1'b1;
    step(3);
    check("idle_v", {31'd0, link_v_o}, 32'd0);
    check("idle_rdy", {31'd0, link_ready_and_o}, 32'd1);
    check("idle_sent", sent_o, 32'd0);
    check("idle_recv", received_o, 32'd0);
    check("idle_err", {31'd0, error_o}, 32'd0);

    // transmit, no loopback: flit = data<<7 | cord
    en = 1'b1; dest = 5'h13; drv_ready = 1'b1;
    step(1);
    check("tx1_v", {31'd0, link_v_o}, 32'd1);
    check("tx1_data", link_data_o, 32'h0000_8013);
    check("tx1_sent", sent_o, 32'd1);
    step(1);
    check("tx_gap_v", {31'd0, link_v_o}, 32'd0);
    check("tx_gap_sent", sent_o, 32'd1);
    step(1);
    check("tx2_v", {31'd0, link_v_o}, 32'd1);
    check("tx2_data", link_data_o, 32'h0001_0093);
    check("tx2_sent", sent_o, 32'd2);

    // back-pressure from a fresh reset
    en = 1'b0;
    do_reset();
    en = 1'b1; drv_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step(1);
      check($sformatf("bp_v_%0d", i), {31'd0, link_v_o}, 32'd1);
      check($sformatf("bp_data_%0d", i), link_data_o, 32'h0000_8013);
      check($sformatf("bp_sent_%0d", i), sent_o, 32'd1);
    end
    drv_ready = 1'b1;
    step(1);
    check("bp_rel_v", {31'd0, link_v_o}, 32'd0);
    step(1);
    check("bp_rel_data", link_data_o, 32'h0001_0093);
    check("bp_rel_sent", sent_o, 32'd2);

    // full loopback, long enough for the 8-bit pattern to wrap
    en = 1'b0;
    do_reset();
    loop = 1'b1; en = 1'b1;
    for (int k = 1; k <= 600; k++) begin
      step(1);
      check($sformatf("lb_sent_%0d", k), sent_o, 32'((k + 1) / 2));
      check($sformatf("lb_recv_%0d", k), received_o, 32'((k - 1) / 2));
    end
    check("lb_err", {31'd0, error_o}, 32'd0);

    // error injection: first expected data is 0x0100, send 0x0101
    loop = 1'b0; en = 1'b0;
    do_reset();
    drv_v = 1'b1; drv_data = 32'h0000_8080;
    step(1);
    drv_v = 1'b0;
    check("inj_err_pre", {31'd0, error_o}, 32'd0);
    check("inj_rdy_full", {31'd0, link_ready_and_o}, 32'd0);
    step(1);
    check("inj_err", {31'd0, error_o}, 32'd1);
    check("inj_recv", received_o, 32'd1);
    drv_v = 1'b1; drv_data = 32'h0001_0080;
    step(1);
    drv_v = 1'b0;
    step(1);
    check("inj_sticky", {31'd0, error_o}, 32'd1);
    check("inj_recv2", received_o, 32'd2);
    en = 1'b1;
    step(4);
    check("inj_sent", sent_o, 32'd2);
    check("inj_sticky2", {31'd0, error_o}, 32'd1);

    // asynchronous reset in the middle of looped traffic
    loop = 1'b1;
    step(7);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_v", {31'd0, link_v_o}, 32'd0);
    check("arst_err", {31'd0, error_o}, 32'd0);
    check("arst_sent", sent_o, 32'd0);
    check("arst_recv", received_o, 32'd0);
    check("arst_rdy", {31'd0, link_ready_and_o}, 32'd1);
    step(1);
    rst_n = 1'b1;
    step(1);
    check("arst_first_v", {31'd0, link_v_o}, 32'd1);
    check("arst_first_data", link_data_o, 32'h0000_8013);
    step(20);
    check("arst_recv_after", received_o, 32'd10);
    check("arst_err_after", {31'd0, error_o}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
